// File: rtl/sequenciador_calculadora.sv
// Command sequencer for the 8-bit accumulator calculator:
// queues commands, issues them, captures results, composes CLEAR.
module sequenciador_calculadora #(
  parameter int PROFUNDIDADE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_dado,
  output logic       cmd_ready,
  output logic [7:0] calc_entrada,
  output logic [2:0] calc_codigo,
  input  logic [7:0] calc_saida,
  output logic [7:0] resultado,
  output logic       resultado_valid,
  output logic       ocupado,
  output logic       erro
);

  localparam int AW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
  localparam logic [AW:0] CHEIO = (AW+1)'(PROFUNDIDADE);

  localparam logic [2:0] OP_SHOW_IN  = 3'b000;
  localparam logic [2:0] OP_ADD      = 3'b001;
  localparam logic [2:0] OP_SUB      = 3'b010;
  localparam logic [2:0] OP_SHOW_ACC = 3'b011;
  localparam logic [2:0] OP_CLEAR    = 3'b100;
  localparam logic [2:0] COD_NOP     = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CAPT,
    EXEC_CLR
  } estado_t;

  logic [10:0]   mem_q [PROFUNDIDADE];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  estado_t    state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] calc_entrada_q, calc_entrada_d;
  logic [2:0] calc_codigo_q, calc_codigo_d;
  logic [7:0] resultado_q, resultado_d;
  logic       resultado_valid_q, resultado_valid_d;
  logic       erro_q, erro_d;

  logic        aceito;
  logic        legal;
  logic        push;
  logic        pop;
  logic [10:0] head;

  assign cmd_ready       = (count_q != CHEIO);
  assign calc_entrada    = calc_entrada_q;
  assign calc_codigo     = calc_codigo_q;
  assign resultado       = resultado_q;
  assign resultado_valid = resultado_valid_q;
  assign erro            = erro_q;
  assign ocupado         = (state_q != IDLE) || (count_q != '0);

  always_comb begin
    aceito = cmd_valid && cmd_ready;
    legal  = (cmd_op <= OP_CLEAR);
    push   = aceito && legal;
    pop    = (state_q == IDLE) && (count_q != '0);
    head   = mem_q[rd_ptr_q];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    calc_entrada_d    = calc_entrada_q;
    calc_codigo_d     = calc_codigo_q;
    resultado_d       = resultado_q;
    resultado_valid_d = 1'b0;
    erro_d            = erro_q | (aceito && !legal);
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          op_d           = head[10:8];
          calc_entrada_d = head[7:0];
          if (head[10:8] == OP_CLEAR)
            calc_codigo_d = OP_SHOW_ACC;
          else
            calc_codigo_d = {1'b0, head[9:8]};
          state_d = EXEC;
        end
      end
      EXEC: begin
        calc_codigo_d = COD_NOP;
        if (op_q == OP_ADD || op_q == OP_SUB)
          state_d = IDLE;
        else
          state_d = CAPT;
      end
      CAPT: begin
        // CLEAR subtracts the accumulator value just read back
        if (op_q == OP_CLEAR) begin
          calc_codigo_d  = OP_SUB;
          calc_entrada_d = calc_saida;
          state_d        = EXEC_CLR;
        end else begin
          resultado_d       = calc_saida;
          resultado_valid_d = 1'b1;
          state_d           = IDLE;
        end
      end
      EXEC_CLR: begin
        calc_codigo_d = COD_NOP;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      state_q           <= IDLE;
      op_q              <= OP_SHOW_IN;
      calc_entrada_q    <= '0;
      calc_codigo_q     <= COD_NOP;
      resultado_q       <= '0;
      resultado_valid_q <= 1'b0;
      erro_q            <= 1'b0;
    end else begin
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      count_q           <= count_d;
      state_q           <= state_d;
      op_q              <= op_d;
      calc_entrada_q    <= calc_entrada_d;
      calc_codigo_q     <= calc_codigo_d;
      resultado_q       <= resultado_d;
      resultado_valid_q <= resultado_valid_d;
      erro_q            <= erro_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_dado};
  end

endmodule

// File: tb/tb_sequenciador_calculadora.sv
// Bench for sequenciador_calculadora with a calculator model
// and a command-level reference of the accumulator.
module tb_sequenciador_calculadora;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'b000;
  logic [7:0] cmd_dado = 8'h00;
  logic       cmd_ready;
  logic [7:0] calc_entrada;
  logic [2:0] calc_codigo;
  logic [7:0] calc_saida;
  logic [7:0] resultado;
  logic       resultado_valid;
  logic       ocupado;
  logic       erro;

  int total = 0;
  int bad = 0;

  sequenciador_calculadora #(.PROFUNDIDADE(4)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_op(cmd_op),
    .cmd_dado(cmd_dado),
    .cmd_ready(cmd_ready),
    .calc_entrada(calc_entrada),
    .calc_codigo(calc_codigo),
    .calc_saida(calc_saida),
    .resultado(resultado),
    .resultado_valid(resultado_valid),
    .ocupado(ocupado),
    .erro(erro)
  );

  always #5 clk = ~clk;

  // Calculator: 000 show input, 001 add, 010 sub, 011 show acc, else hold
  logic [7:0]  acc_hw;
  logic [10:0] log_q[$];
  always @(posedge clk) begin
    if (rst) begin
      acc_hw     <= 8'h00;
      calc_saida <= 8'h00;
    end else begin
      if (calc_codigo != 3'b111) log_q.push_back({calc_codigo, calc_entrada});
      case (calc_codigo)
        3'b000: calc_saida <= calc_entrada;
        3'b001: begin
          acc_hw     <= acc_hw + calc_entrada;
          calc_saida <= acc_hw + calc_entrada;
        end
        3'b010: begin
          acc_hw     <= acc_hw - calc_entrada;
          calc_saida <= acc_hw - calc_entrada;
        end
        3'b011: calc_saida <= acc_hw;
        default: ;
      endcase
    end
  end

  logic [7:0] got_q[$];
  logic       prev_v = 1'b0;
  int         spacing_err = 0;
  always @(negedge clk) begin
    if (resultado_valid === 1'b1) begin
      got_q.push_back(resultado);
      if (prev_v === 1'b1) spacing_err++;
    end
    prev_v = resultado_valid;
  end

  // Reference: command-level semantics, applied in push order
  logic [7:0] m_acc = 8'h00;
  logic [7:0] exp_q[$];
  int         gi = 0;
  int         stalls = 0;

  task automatic model(input logic [2:0] op, input logic [7:0] d);
    case (op)
      3'd0: exp_q.push_back(d);
      3'd1: m_acc = m_acc + d;
      3'd2: m_acc = m_acc - d;
      3'd3: exp_q.push_back(m_acc);
      3'd4: m_acc = 8'h00;
      default: ;
    endcase
  endtask

  task automatic push(input logic [2:0] op, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dado  = d;
    if (!cmd_ready) stalls++;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL push_timeout cmd_ready=%b required=1", cmd_ready);
    end else begin
      @(posedge clk);
      model(op, d);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while (ocupado && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL drain_timeout ocupado=%b required=0", ocupado);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({ocupado, calc_codigo, calc_entrada, resultado, resultado_valid, erro, cmd_ready}
        !== {1'b0, 3'b111, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state got occ=%b cod=%b ent=%h res=%h v=%b err=%b rdy=%b",
               ocupado, calc_codigo, calc_entrada, resultado, resultado_valid, erro, cmd_ready);
    end
    rst = 1'b0;
    m_acc = 8'h00;
    exp_q.delete();
    gi = got_q.size();
  endtask

  task automatic test_accumulate();
    exp_q.delete();
    gi = got_q.size();
    push(3'd1, 8'd5);
    push(3'd1, 8'd10);
    push(3'd3, 8'h00);
    drain();
    total++;
    if (got_q.size() - gi !== 1) begin
      bad++;
      $display("FAIL acc_pulses got=%0d required=1", got_q.size() - gi);
    end
    total++;
    if (got_q.size() > gi && got_q[gi] !== 8'd15) begin
      bad++;
      $display("FAIL acc_value got=%0d required=15", got_q[gi]);
    end
    gi = got_q.size();
  endtask

  task automatic test_wrap();
    exp_q.delete();
    gi = got_q.size();
    push(3'd2, 8'd20);
    push(3'd3, 8'h00);
    push(3'd1, 8'd5);
    push(3'd3, 8'h00);
    drain();
    total++;
    if (got_q.size() - gi !== 2) begin
      bad++;
      $display("FAIL wrap_pulses got=%0d required=2", got_q.size() - gi);
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (got_q.size() > gi + i && got_q[gi+i] !== (i == 0 ? 8'hFB : 8'h00)) begin
        bad++;
        $display("FAIL wrap_value[%0d] got=%h required=%h", i, got_q[gi+i],
                 (i == 0 ? 8'hFB : 8'h00));
      end
    end
    gi = got_q.size();
  endtask

  task automatic test_clear();
    int li;
    exp_q.delete();
    gi = got_q.size();
    li = log_q.size();
    push(3'd1, 8'h37);
    push(3'd4, 8'hEE);
    push(3'd3, 8'h00);
    drain();
    total++;
    if (got_q.size() - gi !== 1) begin
      bad++;
      $display("FAIL clear_pulses got=%0d required=1", got_q.size() - gi);
    end
    total++;
    if (got_q.size() > gi && got_q[gi] !== 8'h00) begin
      bad++;
      $display("FAIL clear_value got=%h required=00", got_q[gi]);
    end
    total++;
    if (log_q.size() - li !== 4) begin
      bad++;
      $display("FAIL clear_issue_count got=%0d required=4", log_q.size() - li);
    end else begin
      total++;
      if ({log_q[li+1][10:8], log_q[li+2]} !== {3'b011, 3'b010, 8'h37}) begin
        bad++;
        $display("FAIL clear_sequence got=%b,%b/%h required=011,010/37",
                 log_q[li+1][10:8], log_q[li+2][10:8], log_q[li+2][7:0]);
      end
    end
    gi = got_q.size();
  endtask

  task automatic test_show_latency();
    gi = got_q.size();
    exp_q.delete();
    push(3'd0, 8'hA5);
    @(negedge clk);
    total++;
    if (calc_codigo !== 3'b111) begin
      bad++;
      $display("FAIL lat_cyc0 codigo=%b required=111", calc_codigo);
    end
    @(posedge clk); #1;
    total++;
    if ({calc_codigo, calc_entrada} !== {3'b000, 8'hA5}) begin
      bad++;
      $display("FAIL lat_cyc1 codigo=%b ent=%h required=000 a5", calc_codigo, calc_entrada);
    end
    @(posedge clk); #1;
    total++;
    if (resultado_valid !== 1'b0) begin
      bad++;
      $display("FAIL lat_cyc2 valid=%b required=0", resultado_valid);
    end
    @(posedge clk); #1;
    total++;
    if ({resultado_valid, resultado} !== {1'b1, 8'hA5}) begin
      bad++;
      $display("FAIL lat_cyc3 valid=%b res=%h required=1 a5", resultado_valid, resultado);
    end
    @(posedge clk); #1;
    total++;
    if ({resultado_valid, resultado} !== {1'b0, 8'hA5}) begin
      bad++;
      $display("FAIL lat_cyc4 valid=%b res=%h required=0 a5", resultado_valid, resultado);
    end
    drain();
    gi = got_q.size();
  endtask

  task automatic test_backpressure();
    exp_q.delete();
    gi = got_q.size();
    stalls = 0;
    for (int i = 1; i <= 8; i++) push(3'd0, 8'(i));
    drain();
    total++;
    if (stalls == 0) begin
      bad++;
      $display("FAIL bp_ready_low stalls=%0d required>0", stalls);
    end
    total++;
    if (got_q.size() - gi !== 8) begin
      bad++;
      $display("FAIL bp_pulses got=%0d required=8", got_q.size() - gi);
    end
    for (int i = 0; i < 8 && gi + i < got_q.size(); i++) begin
      total++;
      if (got_q[gi+i] !== 8'(i + 1)) begin
        bad++;
        $display("FAIL bp_order[%0d] got=%0d required=%0d", i, got_q[gi+i], i + 1);
      end
    end
    gi = got_q.size();
  endtask

  task automatic test_illegal();
    push(3'b101, 8'h12);
    @(negedge clk);
    total++;
    if ({erro, ocupado, cmd_ready} !== 3'b101) begin
      bad++;
      $display("FAIL illegal_set err=%b occ=%b rdy=%b required=1 0 1", erro, ocupado, cmd_ready);
    end
    push(3'd1, 8'd0);
    drain();
    total++;
    if (erro !== 1'b1) begin
      bad++;
      $display("FAIL illegal_sticky err=%b required=1", erro);
    end
  endtask

  task automatic test_reset_mid();
    push(3'd4, 8'h00);
    push(3'd0, 8'h11);
    push(3'd0, 8'h22);
    push(3'd0, 8'h33);
    @(negedge clk);
    total++;
    if ({calc_codigo, ocupado} !== {3'b010, 1'b1}) begin
      bad++;
      $display("FAIL rstmid_pre codigo=%b occ=%b required=010 1", calc_codigo, ocupado);
    end
    rst = 1'b1;
    gi = got_q.size();
    @(posedge clk); #1;
    total++;
    if ({ocupado, calc_codigo, erro, resultado_valid} !== {1'b0, 3'b111, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rstmid_post occ=%b cod=%b err=%b v=%b required=0 111 0 0",
               ocupado, calc_codigo, erro, resultado_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    m_acc = 8'h00;
    exp_q.delete();
    repeat (6) @(negedge clk);
    total++;
    if (got_q.size() !== gi || ocupado !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_quiet pulses=%0d occ=%b required=0 0", got_q.size() - gi, ocupado);
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    exp_q.delete();
    gi = got_q.size();
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 4));
      push(op, 8'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain();
    total++;
    if (got_q.size() - gi !== exp_q.size()) begin
      bad++;
      $display("FAIL rand_pulses got=%0d required=%0d", got_q.size() - gi, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && gi + i < got_q.size(); i++) begin
      total++;
      if (got_q[gi+i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rand_value[%0d] got=%h required=%h", i, got_q[gi+i], exp_q[i]);
      end
    end
    gi = got_q.size();
    total++;
    if (spacing_err !== 0) begin
      bad++;
      $display("FAIL pulse_spacing consecutive=%0d required=0", spacing_err);
    end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_wrap();
    test_clear();
    test_show_latency();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
